// File: rtl/inv_clark.sv
// Inverse Clarke transform: alpha/beta currents -> u/v/w phase currents.
// A rising edge on iIc_en starts a two-cycle conversion (MUL then SUM) with saturated v/w outputs.
module inv_clark (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iIc_en,
  input  logic signed [11:0] iIalpha,
  input  logic signed [11:0] iIbeta,
  output logic signed [11:0] oIu,
  output logic signed [11:0] oIv,
  output logic signed [11:0] oIw,
  output logic               oIc_done,
  output logic               oBusy,
  output logic               oSat
);

  localparam int K_SQRT3_2 = 886;
  localparam logic signed [22:0] K_COEF = $signed({12'd0, 11'(K_SQRT3_2)});

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_en_prev;
  logic signed [11:0] r_alpha;
  logic signed [11:0] r_beta;
  logic signed [13:0] r_p;

  logic               w_start;
  logic signed [22:0] w_beta_ext;
  logic signed [22:0] w_prod;
  logic signed [22:0] w_p_full;
  logic signed [13:0] w_h;
  logic signed [13:0] w_v;
  logic signed [13:0] w_w;
  logic               w_v_clip;
  logic               w_w_clip;
  logic signed [11:0] w_v_sat;
  logic signed [11:0] w_w_sat;

  assign w_start = iIc_en & ~r_en_prev;

  // Product fits in 22 bits; the arithmetic shift floors toward -inf.
  assign w_beta_ext = $signed({{11{r_beta[11]}}, r_beta});
  assign w_prod     = w_beta_ext * K_COEF;
  assign w_p_full   = w_prod >>> 10;

  assign w_h = $signed({{2{r_alpha[11]}}, r_alpha}) >>> 1;
  assign w_v = -w_h + r_p;
  assign w_w = -w_h - r_p;

  // A 14-bit value fits 12 bits only when its top three bits agree.
  assign w_v_clip = (w_v[13:11] != 3'b000) && (w_v[13:11] != 3'b111);
  assign w_w_clip = (w_w[13:11] != 3'b000) && (w_w[13:11] != 3'b111);
  assign w_v_sat  = w_v_clip ? (w_v[13] ? 12'sh800 : 12'sh7FF) : w_v[11:0];
  assign w_w_sat  = w_w_clip ? (w_w[13] ? 12'sh800 : 12'sh7FF) : w_w[11:0];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_MUL;
      S_MUL:   w_state_next = S_SUM;
      S_SUM:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    oBusy = (r_state != S_IDLE);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_en_prev <= 1'b0;
      r_alpha   <= '0;
      r_beta    <= '0;
      r_p       <= '0;
      oIu       <= '0;
      oIv       <= '0;
      oIw       <= '0;
      oSat      <= 1'b0;
      oIc_done  <= 1'b0;
    end else begin
      r_en_prev <= iIc_en;
      oIc_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_alpha <= iIalpha;
            r_beta  <= iIbeta;
          end
        end
        S_MUL: begin
          r_p <= w_p_full[13:0];
        end
        S_SUM: begin
          oIu      <= r_alpha;
          oIv      <= w_v_sat;
          oIw      <= w_w_sat;
          oSat     <= w_v_clip | w_w_clip;
          oIc_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_clark.sv
// Directed-vector bench for inv_clark; inputs driven and outputs sampled on the falling edge.
module tb_inv_clark;

  logic               iClk;
  logic               iRst_n;
  logic               iIc_en;
  logic signed [11:0] iIalpha;
  logic signed [11:0] iIbeta;
  logic signed [11:0] oIu;
  logic signed [11:0] oIv;
  logic signed [11:0] oIw;
  logic               oIc_done;
  logic               oBusy;
  logic               oSat;

  int n_tests;
  int n_fail;

  inv_clark dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iIc_en   (iIc_en),
    .iIalpha  (iIalpha),
    .iIbeta   (iIbeta),
    .oIu      (oIu),
    .oIv      (oIv),
    .oIw      (oIw),
    .oIc_done (oIc_done),
    .oBusy    (oBusy),
    .oSat     (oSat)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic test_reset();
    iRst_n = 1'b0; iIc_en = 1'b0; iIalpha = '0; iIbeta = '0;
    repeat (3) @(negedge iClk);
    n_tests++;
    if ({oIu, oIv, oIw} !== 36'd0 || oIc_done !== 1'b0 || oBusy !== 1'b0 || oSat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: u=%0d v=%0d w=%0d done=%b busy=%b sat=%b, required all 0",
               oIu, oIv, oIw, oIc_done, oBusy, oSat);
    end
    iRst_n = 1'b1;
    repeat (2) @(negedge iClk);
    n_tests++;
    if (oBusy !== 1'b0 || oIc_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", oBusy, oIc_done);
    end
  endtask

  task automatic test_vectors();
    logic signed [11:0] va [5] = '{12'sd1000, 12'sd0, 12'sd0, -12'sd3, -12'sd2048};
    logic signed [11:0] vb [5] = '{12'sd0, 12'sd1000, -12'sd1000, 12'sd0, 12'sd2047};
    logic signed [11:0] ev [5] = '{-12'sd500, 12'sd865, -12'sd866, 12'sd2, 12'sd2047};
    logic signed [11:0] ew [5] = '{-12'sd500, -12'sd865, 12'sd866, 12'sd2, -12'sd747};
    logic               es [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      iIalpha = va[i]; iIbeta = vb[i]; iIc_en = 1'b1;
      @(negedge iClk);
      iIc_en = 1'b0;
      n_tests++;
      if (oBusy !== 1'b1 || oIc_done !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_mul_cycle: busy=%b done=%b, required 1 0", i, oBusy, oIc_done);
      end
      @(negedge iClk);
      n_tests++;
      if (oBusy !== 1'b1 || oIc_done !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_sum_cycle: busy=%b done=%b, required 1 0", i, oBusy, oIc_done);
      end
      @(negedge iClk);
      n_tests++;
      if (oIu !== va[i] || oIv !== ev[i] || oIw !== ew[i] || oSat !== es[i] ||
          oIc_done !== 1'b1 || oBusy !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_result: u=%0d v=%0d w=%0d sat=%b done=%b busy=%b, required u=%0d v=%0d w=%0d sat=%b done=1 busy=0",
                 i, oIu, oIv, oIw, oSat, oIc_done, oBusy, va[i], ev[i], ew[i], es[i]);
      end
      $display("[TB] vec%0d alpha=%0d beta=%0d -> u=%0d v=%0d w=%0d sat=%b", i, va[i], vb[i], oIu, oIv, oIw, oSat);
      @(negedge iClk);
      n_tests++;
      if (oIc_done !== 1'b0 || oIv !== ev[i]) begin
        n_fail++;
        $display("FAIL vec%0d_hold: done=%b v=%0d, required done=0 v=%0d", i, oIc_done, oIv, ev[i]);
      end
    end
  endtask

  task automatic test_level_held();
    int dones = 0;
    @(negedge iClk);
    iIalpha = 12'sd0; iIbeta = 12'sd1000; iIc_en = 1'b1;
    repeat (10) begin
      @(negedge iClk);
      if (oIc_done) dones++;
    end
    iIc_en = 1'b0;
    repeat (4) begin
      @(negedge iClk);
      if (oIc_done) dones++;
    end
    n_tests++;
    if (dones != 1 || oIv !== 12'sd865) begin
      n_fail++;
      $display("FAIL level_held: dones=%0d v=%0d, required 1 and 865", dones, oIv);
    end
    $display("[TB] level_held dones=%0d", dones);
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    @(negedge iClk);
    iIalpha = 12'sd1000; iIbeta = 12'sd0; iIc_en = 1'b1;
    @(negedge iClk);
    iIc_en = 1'b0;
    @(negedge iClk);
    iIc_en = 1'b1;
    iIalpha = -12'sd2048; iIbeta = 12'sd2047;
    @(negedge iClk);
    iIc_en = 1'b0;
    n_tests++;
    if (oIc_done !== 1'b1 || oIv !== -12'sd500) begin
      n_fail++;
      $display("FAIL busy_first_done: done=%b v=%0d, required 1 -500", oIc_done, oIv);
    end
    repeat (5) begin
      @(negedge iClk);
      if (oIc_done || oBusy) dones++;
    end
    n_tests++;
    if (dones != 0 || oIv !== -12'sd500) begin
      n_fail++;
      $display("FAIL busy_ignore: extra busy/done cycles=%0d v=%0d, required 0 -500", dones, oIv);
    end
    $display("[TB] busy_ignore extra=%0d", dones);
  endtask

  task automatic test_back_to_back();
    @(negedge iClk);
    iIalpha = 12'sd0; iIbeta = -12'sd1000; iIc_en = 1'b1;
    @(negedge iClk);
    iIc_en = 1'b0;
    repeat (2) @(negedge iClk);
    n_tests++;
    if (oIc_done !== 1'b1 || oIv !== -12'sd866 || oIw !== 12'sd866) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b v=%0d w=%0d, required 1 -866 866", oIc_done, oIv, oIw);
    end
    iIalpha = -12'sd2048; iIbeta = 12'sd2047; iIc_en = 1'b1;
    @(negedge iClk);
    iIc_en = 1'b0;
    n_tests++;
    if (oBusy !== 1'b1 || oIc_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", oBusy, oIc_done);
    end
    repeat (2) @(negedge iClk);
    n_tests++;
    if (oIc_done !== 1'b1 || oIu !== -12'sd2048 || oIv !== 12'sd2047 || oIw !== -12'sd747 || oSat !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b u=%0d v=%0d w=%0d sat=%b, required 1 -2048 2047 -747 1",
               oIc_done, oIu, oIv, oIw, oSat);
    end
    $display("[TB] back_to_back u=%0d v=%0d w=%0d sat=%b", oIu, oIv, oIw, oSat);
  endtask

  task automatic test_input_change();
    @(negedge iClk);
    iIalpha = 12'sd1000; iIbeta = 12'sd0; iIc_en = 1'b1;
    @(negedge iClk);
    iIc_en = 1'b0; iIalpha = -12'sd3; iIbeta = 12'sd1000;
    repeat (2) @(negedge iClk);
    n_tests++;
    if (oIc_done !== 1'b1 || oIu !== 12'sd1000 || oIv !== -12'sd500 || oIw !== -12'sd500 || oSat !== 1'b0) begin
      n_fail++;
      $display("FAIL input_change: done=%b u=%0d v=%0d w=%0d sat=%b, required 1 1000 -500 -500 0",
               oIc_done, oIu, oIv, oIw, oSat);
    end
    $display("[TB] input_change u=%0d v=%0d w=%0d", oIu, oIv, oIw);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(negedge iClk);
    iIalpha = -12'sd2048; iIbeta = 12'sd2047; iIc_en = 1'b1;
    @(negedge iClk);
    iIc_en = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    n_tests++;
    if ({oIu, oIv, oIw} !== 36'd0 || oBusy !== 1'b0 || oIc_done !== 1'b0 || oSat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_clear: u=%0d v=%0d w=%0d busy=%b done=%b sat=%b, required all 0",
               oIu, oIv, oIw, oBusy, oIc_done, oSat);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (4) begin
      @(negedge iClk);
      if (oIc_done || oBusy) dones++;
    end
    n_tests++;
    if (dones != 0 || {oIu, oIv, oIw} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_abort_nodone: busy/done cycles=%0d u=%0d v=%0d w=%0d, required 0 and outputs 0",
               dones, oIu, oIv, oIw);
    end
    $display("[TB] reset_abort extra=%0d", dones);
  endtask

  task automatic test_start_after_reset();
    @(negedge iClk);
    iRst_n = 1'b0; iIc_en = 1'b1; iIalpha = -12'sd3; iIbeta = 12'sd0;
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);
    iIc_en = 1'b0;
    n_tests++;
    if (oBusy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_start: busy=%b, required 1", oBusy);
    end
    repeat (2) @(negedge iClk);
    n_tests++;
    if (oIc_done !== 1'b1 || oIu !== -12'sd3 || oIv !== 12'sd2 || oIw !== 12'sd2) begin
      n_fail++;
      $display("FAIL post_reset_result: done=%b u=%0d v=%0d w=%0d, required 1 -3 2 2", oIc_done, oIu, oIv, oIw);
    end
    $display("[TB] start_after_reset u=%0d v=%0d w=%0d", oIu, oIv, oIw);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_vectors();
    test_level_held();
    test_busy_ignore();
    test_back_to_back();
    test_input_change();
    test_reset_abort();
    test_start_after_reset();
    repeat (2) @(negedge iClk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
